uart_frame_tx: RTL

UART transmit framer and serializer, the transmit-side counterpart of the receive deframer. Accepts a parallel data word with a one-cycle send strobe. Builds the frame {stop bits, parity, data, start} and shifts it out LSB-first on a single serial line. The line idles high and each bit is held for a fixed number of clocks.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_frame_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: framer state encoding, frame width helper and line levels.
// Used by both the transmit framer and the receive deframer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  function automatic int frame_w(input int data_bits, input int parity_en, input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick marks the last clock of each CLKS_PER_BIT-long bit.
// Latency: combinational tick from the registered count; clear restarts the period at 0.
// Backpressure: none; counts whenever enable is high.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = enable && !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_frame_tx.sv
// UART transmit framer: start, LSB-first data, optional parity, stop bits (odd parity if UART_TX_ODD_PARITY_EN).
// Latency: start bit on the line the cycle after acceptance; done_flag one cycle after the last stop bit.
// Backpressure: send_flag is ignored (not queued) while busy is high.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] raw_data,
  input  logic                 send_flag,
  output logic                 tx_serial,
  output logic                 busy,
  output logic                 done_flag
);

  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 bit_tick;
  logic                 par_calc;

`ifdef UART_TX_ODD_PARITY_EN
  assign par_calc = ~^raw_data;
`else
  assign par_calc = ^raw_data;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (state_q != IDLE),
    .clear   (accept),
    .bit_tick(bit_tick)
  );

  // tx_d is the level for the next bit period; the shift register always holds the next data bit in [0].
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = LINE_IDLE;
        busy_d = 1'b0;
        if (send_flag) begin
          accept    = 1'b1;
          shift_d   = raw_data;
          par_d     = par_calc;
          bit_cnt_d = '0;
          tx_d      = LINE_START;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (bit_tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = LINE_IDLE;
              state_d = STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          tx_d      = LINE_IDLE;
          bit_cnt_d = '0;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            tx_d      = LINE_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      default: begin
        tx_d      = LINE_IDLE;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_serial = tx_q;
  assign busy      = busy_q;
  assign done_flag = done_q;

endmodule
